// File: rtl/sram_ctrl.sv
// sram_ctrl: single-request SRAM controller with fixed read latency and range checking
module sram_ctrl #(
   parameter int ADDRW      = 32,
   parameter int DATAW      = 32,
   parameter int MASKW      = DATAW / 8,
   parameter int MEM_DEPTH  = 1024,
   parameter int RD_LATENCY = 1,
   localparam int OFFW      = $clog2(MASKW),
   localparam int IDXW      = $clog2(MEM_DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [ADDRW-1:0] addr_i,
   input  logic [DATAW-1:0] wdata_i,
   input  logic [MASKW-1:0] mask_i,
   input  logic             we_i,
   input  logic             valid_i,
   output logic [DATAW-1:0] rdata_o,
   output logic             resp_o,
   output logic             err_o,
   output logic             mem_en_o,
   output logic             mem_we_o,
   output logic [IDXW-1:0]  mem_addr_o,
   output logic [DATAW-1:0] mem_wdata_o,
   output logic [MASKW-1:0] mem_wmask_o,
   input  logic [DATAW-1:0] mem_rdata_i
);
   localparam int CNTW = $clog2(RD_LATENCY + 1);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
   logic [1:0]      state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            we_q, we_d, err_q, err_d;
   logic            in_range, accept, mem_go;
   // Upper address bits beyond the SRAM word range must all be zero; a shift
   // keeps this valid even when the index covers the whole address.
   assign in_range = (addr_i >> (OFFW + IDXW)) == '0;
   assign accept   = rst_ni && state_q == IDLE && valid_i;
   assign mem_go   = accept && in_range;
   assign mem_en_o    = mem_go;
   assign mem_we_o    = mem_go && we_i;
   assign mem_addr_o  = mem_go ? addr_i[OFFW +: IDXW] : '0;
   assign mem_wdata_o = mem_go ? wdata_i : '0;
   assign mem_wmask_o = mem_go ? mask_i : '0;
   assign resp_o  = rst_ni && state_q == RESP;
   assign err_o   = resp_o && err_q;
   assign rdata_o = (resp_o && !we_q && !err_q) ? mem_rdata_i : '0;
   // Next-state logic: latch request kind at acceptance, count down read latency
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (accept) begin
            we_d  = we_i;
            err_d = !in_range;
            if (we_i || !in_range || RD_LATENCY == 1) state_d = RESP;
            else begin
               state_d = WAIT;
               cnt_d   = CNTW'(RD_LATENCY - 1);
            end
         end
         WAIT: if (cnt_q <= CNTW'(1)) begin
            state_d = RESP;
            cnt_d   = '0;
         end else cnt_d = cnt_q - CNTW'(1);
         default: state_d = IDLE;
      endcase
   end
   // State registers with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: randomized bench for sram_ctrl at read latencies 1 and 3
module tb_sram_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b1;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  mask = '0;
   logic        we = 1'b0;
   logic        valid [2];
   logic [31:0] rdata [2];
   logic        resp [2];
   logic        err [2];
   logic        men [2];
   logic        mwe [2];
   logic [9:0]  maddr [2];
   logic [31:0] mwdata [2];
   logic [3:0]  mwmask [2];
   logic [31:0] mrdata [2];
   logic [31:0] sram0 [1024];
   logic [31:0] sram1 [1024];
   logic [31:0] p1;
   logic [31:0] p3 [3];
   logic [31:0] ref_mem [2][1024];
   int vectors = 0;
   int miscompares = 0;
   localparam logic [31:0] FILL = 32'hBAD0_BAD0;

   always #5 clk = ~clk;

   sram_ctrl #(.RD_LATENCY(1)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .wdata_i(wdata), .mask_i(mask),
      .we_i(we), .valid_i(valid[0]), .rdata_o(rdata[0]), .resp_o(resp[0]), .err_o(err[0]),
      .mem_en_o(men[0]), .mem_we_o(mwe[0]), .mem_addr_o(maddr[0]), .mem_wdata_o(mwdata[0]),
      .mem_wmask_o(mwmask[0]), .mem_rdata_i(mrdata[0]));

   sram_ctrl #(.RD_LATENCY(3)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .wdata_i(wdata), .mask_i(mask),
      .we_i(we), .valid_i(valid[1]), .rdata_o(rdata[1]), .resp_o(resp[1]), .err_o(err[1]),
      .mem_en_o(men[1]), .mem_we_o(mwe[1]), .mem_addr_o(maddr[1]), .mem_wdata_o(mwdata[1]),
      .mem_wmask_o(mwmask[1]), .mem_rdata_i(mrdata[1]));

   assign mrdata[0] = p1;
   assign mrdata[1] = p3[2];

   // SRAM macro with 1-cycle read latency; read data only valid in the exact cycle
   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 1024; i++) sram0[i] <= '0;
      end else if (men[0] && mwe[0]) begin
         for (int b = 0; b < 4; b++) if (mwmask[0][b]) sram0[maddr[0]][8*b +: 8] <= mwdata[0][8*b +: 8];
      end
      p1 <= (men[0] && !mwe[0]) ? sram0[maddr[0]] : FILL;
   end

   // SRAM macro with 3-cycle read latency
   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 1024; i++) sram1[i] <= '0;
      end else if (men[1] && mwe[1]) begin
         for (int b = 0; b < 4; b++) if (mwmask[1][b]) sram1[maddr[1]][8*b +: 8] <= mwdata[1][8*b +: 8];
      end
      p3[0] <= (men[1] && !mwe[1]) ? sram1[maddr[1]] : FILL;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end

   // One request on DUT d, checked against the reference memory and expected latency
   task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
      logic        e;
      logic [9:0]  idx;
      int          lat;
      logic [31:0] exp_rd;
      bit          got;
      e      = (a >> 12) != 0;
      idx    = a[11:2];
      lat    = (w || e || d == 0) ? 1 : 3;
      exp_rd = (w || e) ? 32'h0 : ref_mem[d][idx];
      if (w && !e) for (int b = 0; b < 4; b++) if (m[b]) ref_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
      @(posedge clk); #1;
      addr = a; wdata = wd; mask = m; we = w; valid[d] = 1'b1;
      #1;
      vectors++;
      if (men[d] !== !e) begin miscompares++; $display("FAIL accept_en d%0d a=%h: got %b exp %b", d, a, men[d], !e); end
      vectors++;
      if (resp[d] !== 1'b0) begin miscompares++; $display("FAIL accept_resp d%0d: got %b exp 0", d, resp[d]); end
      if (!e) begin
         vectors++;
         if (mwe[d] !== w || maddr[d] !== idx) begin
            miscompares++; $display("FAIL accept_drive d%0d: got we=%b idx=%h exp we=%b idx=%h", d, mwe[d], maddr[d], w, idx);
         end
         if (w) begin
            vectors++;
            if (mwdata[d] !== wd || mwmask[d] !== m) begin
               miscompares++; $display("FAIL accept_wdata d%0d: got %h/%h exp %h/%h", d, mwdata[d], mwmask[d], wd, m);
            end
         end
      end
      got = 0;
      for (int k = 1; k <= 8 && !got; k++) begin
         @(posedge clk); #1;
         if (resp[d]) begin
            got = 1;
            vectors++;
            if (k != lat) begin miscompares++; $display("FAIL resp_latency d%0d: got %0d exp %0d", d, k, lat); end
            vectors++;
            if (err[d] !== e) begin miscompares++; $display("FAIL resp_err d%0d a=%h: got %b exp %b", d, a, err[d], e); end
            vectors++;
            if (rdata[d] !== exp_rd) begin miscompares++; $display("FAIL resp_rdata d%0d a=%h: got %h exp %h", d, a, rdata[d], exp_rd); end
            valid[d] = 1'b0;
         end else begin
            vectors++;
            if (men[d] !== 1'b0 || err[d] !== 1'b0 || rdata[d] !== 32'h0) begin
               miscompares++; $display("FAIL wait_quiet d%0d: got en=%b err=%b rdata=%h exp 0", d, men[d], err[d], rdata[d]);
            end
         end
      end
      if (!got) begin
         vectors++; miscompares++; valid[d] = 1'b0;
         $display("FAIL resp_timeout d%0d a=%h: got no resp exp resp at %0d", d, a, lat);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         vectors++;
         if ({resp[d], err[d], men[d], mwe[d]} !== 4'b0 || rdata[d] !== 32'h0) begin
            miscompares++; $display("FAIL reset_outputs d%0d: got %b%b%b%b %h exp 0", d, resp[d], err[d], men[d], mwe[d], rdata[d]);
         end
      end
      rst_n = 1'b1; clr = 1'b0;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         vectors++;
         if ({resp[d], err[d], men[d], mwe[d]} !== 4'b0 || rdata[d] !== 32'h0) begin
            miscompares++; $display("FAIL post_reset d%0d: got %b%b%b%b %h exp 0", d, resp[d], err[d], men[d], mwe[d], rdata[d]);
         end
      end
   endtask

   task automatic test_write_read;
      txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0);
   endtask

   task automatic test_byte_mask;
      txn(0, 1'b1, 32'h20, 32'h11223344, 4'h3);
      txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'hC);
      txn(0, 1'b0, 32'h20, 32'h0, 4'h0);
      vectors++;
      if (ref_mem[0][8] !== 32'hAABB3344) begin miscompares++; $display("FAIL mask_model: got %h exp aabb3344", ref_mem[0][8]); end
   endtask

   task automatic test_latency3;
      txn(1, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF);
      txn(1, 1'b0, 32'h10, 32'h0, 4'h0);
      txn(1, 1'b0, 32'h14, 32'h0, 4'h0);
   endtask

   task automatic test_out_of_range;
      txn(0, 1'b1, 32'h0, 32'h01234567, 4'hF);
      txn(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
      txn(0, 1'b0, 32'h0, 32'h0, 4'h0);
      txn(1, 1'b0, 32'h8000_0004, 32'h0, 4'h0);
   endtask

   task automatic test_back_to_back;
      for (int b = 0; b < 4; b++) ref_mem[0][16][8*b +: 8] = 8'h5A + 8'(b);
      @(posedge clk); #1;
      addr = 32'h40; wdata = 32'h5D5C5B5A; mask = 4'hF; we = 1'b1; valid[0] = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (resp[0] !== 1'b1) begin miscompares++; $display("FAIL b2b_resp1: got %b exp 1", resp[0]); end
      addr = 32'h40; we = 1'b0;
      #1;
      vectors++;
      if (men[0] !== 1'b0) begin miscompares++; $display("FAIL b2b_ignore_in_resp: got %b exp 0", men[0]); end
      @(posedge clk); #1;
      vectors++;
      if (resp[0] !== 1'b0 || men[0] !== 1'b1 || mwe[0] !== 1'b0 || maddr[0] !== 10'h10) begin
         miscompares++; $display("FAIL b2b_accept2: got resp=%b en=%b we=%b idx=%h exp 0 1 0 010", resp[0], men[0], mwe[0], maddr[0]);
      end
      @(posedge clk); #1;
      vectors++;
      if (resp[0] !== 1'b1 || rdata[0] !== ref_mem[0][16]) begin
         miscompares++; $display("FAIL b2b_resp2: got %b %h exp 1 %h", resp[0], rdata[0], ref_mem[0][16]);
      end
      valid[0] = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (resp[0] !== 1'b0 || men[0] !== 1'b0) begin miscompares++; $display("FAIL b2b_single_pulse: got %b %b exp 0 0", resp[0], men[0]); end
   endtask

   task automatic test_reset_mid_read;
      int pulses;
      @(posedge clk); #1;
      addr = 32'h10; we = 1'b0; valid[1] = 1'b1;
      #1;
      vectors++;
      if (men[1] !== 1'b1) begin miscompares++; $display("FAIL rst_mid_accept: got %b exp 1", men[1]); end
      @(posedge clk); #1;
      rst_n = 1'b0; valid[1] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      pulses = 0;
      repeat (5) begin
         if (resp[1] || men[1]) pulses++;
         @(posedge clk); #1;
      end
      vectors++;
      if (pulses != 0) begin miscompares++; $display("FAIL rst_mid_no_resp: got %0d exp 0", pulses); end
      txn(1, 1'b0, 32'h10, 32'h0, 4'h0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 60; i++) begin
         logic [31:0] a;
         a = {20'h0, 6'(0), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 7) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
         txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      end
   endtask

   initial begin
      valid[0] = 1'b0;
      valid[1] = 1'b0;
      for (int d = 0; d < 2; d++) for (int i = 0; i < 1024; i++) ref_mem[d][i] = '0;
      test_reset;
      test_write_read;
      test_byte_mask;
      test_latency3;
      test_out_of_range;
      test_back_to_back;
      test_reset_mid_read;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
